programmable_timer: RTL and testbench
=====================================

Name: programmable_timer

Overview:
- Next-generation clock-divided counter peripheral: run-time programmable prescaler, compare register and three counting modes (free-run, periodic, one-shot).
- Adds load, enable, a single-cycle tick strobe and a sticky interrupt flag.
- Sits on the memory-mapped peripheral bus beside other ext peripherals. The bus decoder drives its control inputs and reads its status outputs.

Parameters:
- P_WIDTH, 32, bit width of the main counter, compare value and load value.
- P_PRESCALE_WIDTH, 16, bit width of the prescaler divisor and the internal prescale counter.

Ports:
- I_CLK  input  1  system clock; single clock domain.
- I_RESET  input  1  synchronous, active-high reset.
- I_ENABLE  input  1  level; 1 = prescaler and counter advance, 0 = both hold.
- I_MODE  input  2  00 free-run, 01 periodic, 10 one-shot, 11 reserved (treated as free-run).
- I_PRESCALE  input  P_PRESCALE_WIDTH  tick every I_PRESCALE+1 enabled cycles (0 = every cycle).
- I_COMPARE  input  P_WIDTH  compare value.
- I_LOAD  input  1  single-cycle pulse; loads I_LOAD_VALUE.
- I_LOAD_VALUE  input  P_WIDTH  value written on I_LOAD.
- I_IRQ_CLEAR  input  1  single-cycle pulse; clears O_IRQ.
- O_COUNT  output  P_WIDTH  main counter value (registered).
- O_TICK  output  1  registered 1-cycle pulse, high in the cycle O_COUNT shows a tick-updated value.
- O_IRQ  output  1  sticky match flag.
- O_DONE  output  1  one-shot completed; counter frozen.

Behaviour:
- Reset (synchronous, I_RESET=1 at posedge, overrides everything):
  - O_COUNT=0, O_TICK=0, O_IRQ=0, O_DONE=0.
  - Prescale counter=0; FSM=RUN.
  - Reset mid-operation abandons any partial prescale period.
- Prescaler:
  - Increments on each enabled cycle.
  - Terminal when psc==I_PRESCALE: psc returns to 0 and a tick event occurs.
  - If I_PRESCALE is lowered below the current psc, psc keeps counting, wraps at 2^P_PRESCALE_WIDTH, then matches. No early tick.
- Tick latency: the tick event and the O_COUNT update occur on the same posedge, and O_TICK=1 is registered on that same edge. With I_PRESCALE=N and continuous enable, the first tick follows N+1 enabled cycles after reset or load.
- Counter on a tick event (match = O_COUNT==I_COMPARE before the update):
  - Free-run: O_COUNT+1, wraps from 2^P_WIDTH-1 to 0. Match sets O_IRQ but does not alter counting.
  - Periodic: on match, O_COUNT<=0 and O_IRQ<=1; otherwise +1. Period is I_COMPARE+1 ticks. If I_COMPARE is changed below the current count, counting continues through wrap to 0, then matches.
  - One-shot: on match, O_COUNT holds, O_IRQ<=1, O_DONE<=1, FSM RUN->DONE; otherwise +1.
- FSM states:
  - RUN: normal counting.
  - DONE: prescaler and counter frozen, no ticks, O_DONE=1.
  - DONE->RUN only on I_LOAD or reset. Mode change while in DONE does not leave DONE.
- Disable (I_ENABLE=0): psc, O_COUNT and FSM hold; O_TICK=0. Load and IRQ clear still act.
- Load (I_LOAD=1):
  - O_COUNT<=I_LOAD_VALUE, psc<=0, O_DONE<=0, FSM<=RUN, O_TICK<=0.
  - Load beats a coincident tick: no increment and no match evaluated that cycle.
- IRQ:
  - O_IRQ set on any match event; cleared by I_IRQ_CLEAR.
  - Simultaneous set and clear: set wins, O_IRQ=1.
- All arithmetic is unsigned, modulo its own width. No combinational path from any input to any output.

Decomposition:
- Package timer_pkg:
  - Mode enum: MODE_FREE=2'b00, MODE_PERIODIC=2'b01, MODE_ONESHOT=2'b10.
  - FSM state enum: ST_RUN, ST_DONE.
- One sub-module, tick_prescaler:
  - Parameter P_PRESCALE_WIDTH.
  - Inputs: I_CLK, I_RESET, enable, clear (driven by load or DONE), I_PRESCALE.
  - Output: 1-cycle tick event.
- Top module holds the counter, compare logic, FSM and IRQ.

Test Plan:
- Reset, then I_ENABLE=1, free-run, I_PRESCALE=3 -> O_TICK every 4 cycles; O_COUNT reads 1,2,3 at cycles 4,8,12.
- Periodic, I_PRESCALE=0, I_COMPARE=5 -> O_COUNT 0..5,0,1...; O_IRQ rises on the tick that returns 5->0. I_IRQ_CLEAR drops it. Clear coincident with the next match leaves O_IRQ=1.
- One-shot, I_PRESCALE=1, I_COMPARE=3 -> O_COUNT freezes at 3 with O_DONE=1 and O_IRQ=1, no further O_TICK. Then I_LOAD with value 0 -> O_DONE=0 and counting resumes.
- Free-run, I_LOAD_VALUE=32'hFFFF_FFFE, I_PRESCALE=0 -> O_COUNT FFFF_FFFF then 0 (wrap). I_LOAD coincident with a tick loads exactly I_LOAD_VALUE.
- I_ENABLE low for 10 cycles mid-period with I_PRESCALE=7 -> O_COUNT and tick phase resume unchanged. Synchronous I_RESET mid-period -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the programmable timer: counting modes and the run/done state.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles down to a single-cycle tick event every I_PRESCALE+1 enabled cycles.
module tick_prescaler #(
  parameter int P_PRESCALE_WIDTH = 16
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic [P_PRESCALE_WIDTH-1:0] I_PRESCALE,
  output logic                        tick_o
);

  logic [P_PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic                        terminal;

  // Equality only: a divisor lowered below psc lets psc run through wrap before matching.
  assign terminal = (psc_q == I_PRESCALE);
  assign tick_o   = enable_i && !clear_i && terminal;

  always_comb begin
    psc_d = psc_q;
    if (clear_i) begin
      psc_d = '0;
    end else if (enable_i) begin
      psc_d = terminal ? '0 : psc_q + P_PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/programmable_timer.sv
// Prescaled counter with free-run, periodic and one-shot modes, tick strobe and sticky IRQ.
module programmable_timer
  import timer_pkg::*;
#(
  parameter int P_WIDTH          = 32,
  parameter int P_PRESCALE_WIDTH = 16
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic                        I_ENABLE,
  input  logic [1:0]                  I_MODE,
  input  logic [P_PRESCALE_WIDTH-1:0] I_PRESCALE,
  input  logic [P_WIDTH-1:0]          I_COMPARE,
  input  logic                        I_LOAD,
  input  logic [P_WIDTH-1:0]          I_LOAD_VALUE,
  input  logic                        I_IRQ_CLEAR,
  output logic [P_WIDTH-1:0]          O_COUNT,
  output logic                        O_TICK,
  output logic                        O_IRQ,
  output logic                        O_DONE
);

  state_e             state_q, state_d;
  logic [P_WIDTH-1:0] count_q, count_d;
  logic               tick_q, tick_d;
  logic               irq_q, irq_d;
  logic               tick_evt;
  logic               match;
  logic               irq_set;

  // The prescaler is held at zero while loading or frozen in DONE.
  tick_prescaler #(
    .P_PRESCALE_WIDTH(P_PRESCALE_WIDTH)
  ) u_prescaler (
    .I_CLK     (I_CLK),
    .I_RESET   (I_RESET),
    .enable_i  (I_ENABLE),
    .clear_i   (I_LOAD || (state_q == ST_DONE)),
    .I_PRESCALE(I_PRESCALE),
    .tick_o    (tick_evt)
  );

  assign match = (count_q == I_COMPARE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick_d  = 1'b0;
    irq_set = 1'b0;
    if (I_LOAD) begin
      // Load beats a coincident tick: no increment, no match evaluation.
      count_d = I_LOAD_VALUE;
      state_d = ST_RUN;
    end else if (tick_evt) begin
      tick_d  = 1'b1;
      irq_set = match;
      case (mode_e'(I_MODE))
        MODE_PERIODIC: count_d = match ? '0 : count_q + P_WIDTH'(1);
        MODE_ONESHOT: begin
          if (match) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_q + P_WIDTH'(1);
          end
        end
        default: count_d = count_q + P_WIDTH'(1);
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (I_IRQ_CLEAR) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= ST_RUN;
      count_q <= '0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      irq_q   <= irq_d;
    end
  end

  assign O_COUNT = count_q;
  assign O_TICK  = tick_q;
  assign O_IRQ   = irq_q;
  assign O_DONE  = (state_q == ST_DONE);

endmodule

// File: tb/tb_programmable_timer.sv
// Directed self-checking bench for programmable_timer with an expected-count scoreboard.
module tb_programmable_timer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] prescale;
  logic [31:0] compare;
  logic        load;
  logic [31:0] load_value;
  logic        irq_clear;
  logic [31:0] o_count;
  logic        o_tick;
  logic        o_irq;
  logic        o_done;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  programmable_timer #(
    .P_WIDTH(32),
    .P_PRESCALE_WIDTH(16)
  ) dut (
    .I_CLK       (clk),
    .I_RESET     (reset),
    .I_ENABLE    (enable),
    .I_MODE      (mode),
    .I_PRESCALE  (prescale),
    .I_COMPARE   (compare),
    .I_LOAD      (load),
    .I_LOAD_VALUE(load_value),
    .I_IRQ_CLEAR (irq_clear),
    .O_COUNT     (o_count),
    .O_TICK      (o_tick),
    .O_IRQ       (o_irq),
    .O_DONE      (o_done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Driver/sampling helpers: inputs change and outputs are sampled 1ns after each posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] cnt, input logic tick,
                               input logic irq, input logic done);
    check({tag, "_count"}, o_count, cnt);
    check({tag, "_tick"}, {31'b0, o_tick}, {31'b0, tick});
    check({tag, "_irq"}, {31'b0, o_irq}, {31'b0, irq});
    check({tag, "_done"}, {31'b0, o_done}, {31'b0, done});
  endtask

  // Scoreboard: expect no tick for gap-1 cycles, then a tick carrying the next queued count.
  task automatic tick_after(input int gap);
    logic [31:0] exp;
    for (int i = 1; i < gap; i++) begin
      step();
      check("idle_tick", {31'b0, o_tick}, 32'd0);
    end
    step();
    check("tick", {31'b0, o_tick}, 32'd1);
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_empty: observed count %h with no expected value", o_count);
    end else begin
      exp = exp_q.pop_front();
      check("tick_count", o_count, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] value);
    load       = 1'b1;
    load_value = value;
    step();
    load       = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    mode       = 2'b00;
    prescale   = 16'd0;
    compare    = 32'd0;
    load       = 1'b0;
    load_value = 32'd0;
    irq_clear  = 1'b0;
    step();
    step();
    check_outputs("reset", 32'd0, 1'b0, 1'b0, 1'b0);

    // Free-run, prescale 3: tick every 4 cycles, counts 1,2,3
    reset    = 1'b0;
    enable   = 1'b1;
    prescale = 16'd3;
    compare  = 32'd100;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    tick_after(4);
    tick_after(4);
    tick_after(4);
    check("free_no_irq", {31'b0, o_irq}, 32'd0);

    // Periodic, prescale 0, compare 5
    mode     = 2'b01;
    prescale = 16'd0;
    compare  = 32'd5;
    do_load(32'd0);
    check_outputs("per_load", 32'd0, 1'b0, 1'b0, 1'b0);
    for (int v = 1; v <= 5; v++) exp_q.push_back(32'(v));
    for (int v = 1; v <= 5; v++) tick_after(1);
    check("per_irq_before_match", {31'b0, o_irq}, 32'd0);
    exp_q.push_back(32'd0);
    tick_after(1);
    check("per_irq_on_wrap", {31'b0, o_irq}, 32'd1);
    irq_clear = 1'b1;
    exp_q.push_back(32'd1);
    tick_after(1);
    irq_clear = 1'b0;
    check("per_irq_cleared", {31'b0, o_irq}, 32'd0);
    for (int v = 2; v <= 5; v++) exp_q.push_back(32'(v));
    for (int v = 2; v <= 5; v++) tick_after(1);
    irq_clear = 1'b1;
    exp_q.push_back(32'd0);
    tick_after(1);
    irq_clear = 1'b0;
    check("per_set_beats_clear", {31'b0, o_irq}, 32'd1);

    // One-shot, prescale 1, compare 3
    mode      = 2'b10;
    prescale  = 16'd1;
    compare   = 32'd3;
    irq_clear = 1'b1;
    do_load(32'd0);
    irq_clear = 1'b0;
    check_outputs("os_load", 32'd0, 1'b0, 1'b0, 1'b0);
    for (int v = 1; v <= 3; v++) exp_q.push_back(32'(v));
    for (int v = 1; v <= 3; v++) tick_after(2);
    check("os_not_done_yet", {31'b0, o_done}, 32'd0);
    step();
    check("os_mid_period_tick", {31'b0, o_tick}, 32'd0);
    step();
    check("os_frozen_count", o_count, 32'd3);
    check("os_done", {31'b0, o_done}, 32'd1);
    check("os_irq", {31'b0, o_irq}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("os_no_tick", {31'b0, o_tick}, 32'd0);
      check("os_hold", o_count, 32'd3);
    end
    mode = 2'b00;
    for (int i = 0; i < 4; i++) step();
    check("os_mode_change_stays_done", {31'b0, o_done}, 32'd1);
    check("os_mode_change_count", o_count, 32'd3);
    mode = 2'b10;
    do_load(32'd0);
    check("os_reload_done", {31'b0, o_done}, 32'd0);
    check("os_reload_count", o_count, 32'd0);
    exp_q.push_back(32'd1);
    tick_after(2);

    // Free-run wrap and load coincident with a tick
    mode     = 2'b00;
    prescale = 16'd0;
    compare  = 32'h10;
    do_load(32'hFFFF_FFFE);
    check("wrap_load", o_count, 32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    tick_after(1);
    tick_after(1);
    do_load(32'h1234_5678);
    check("load_beats_tick_count", o_count, 32'h1234_5678);
    check("load_beats_tick_tick", {31'b0, o_tick}, 32'd0);
    exp_q.push_back(32'h1234_5679);
    tick_after(1);

    // Disable mid-period with prescale 7
    prescale = 16'd7;
    do_load(32'd0);
    exp_q.push_back(32'd1);
    tick_after(8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("pre_disable_no_tick", {31'b0, o_tick}, 32'd0);
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("disabled_no_tick", {31'b0, o_tick}, 32'd0);
      check("disabled_hold", o_count, 32'd1);
    end
    enable = 1'b1;
    exp_q.push_back(32'd2);
    tick_after(5);
    exp_q.push_back(32'd3);
    tick_after(8);

    // Synchronous reset mid-period abandons the partial prescale period
    for (int i = 0; i < 3; i++) step();
    check("pre_reset_irq", {31'b0, o_irq}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_outputs("mid_reset", 32'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'd1);
    tick_after(8);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
